// File: rtl/sound_mixer_pkg.sv
// Shared types and register map for the sound mixer family.
package sound_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

  localparam int REG_GAIN_BASE = 0;
  localparam int REG_MUTE      = 8;
  localparam int REG_STATUS    = 9;
  localparam int REG_PEAK      = 10;

  localparam int STAT_OVERRUN = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_CLIP    = 2;

  function automatic int GAIN_UNITY(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

endpackage

// File: rtl/sound_mixer_sat.sv
// Combinational floor-shift and clamp from accumulator width down to OUT_W,
// flagging when the clamp was applied.
module sound_mixer_sat #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Arithmetic shift gives floor rounding for negative sums.
  function automatic logic signed [IN_W-1:0] shift_floor(input logic signed [IN_W-1:0] x);
    return x >>> SHIFT;
  endfunction

  // Returns {clip, value}.
  function automatic logic [OUT_W:0] clamp(input logic signed [IN_W-1:0] x);
    if (x > MAX_V)
      return {1'b1, MAX_V[OUT_W-1:0]};
    else if (x < MIN_V)
      return {1'b1, MIN_V[OUT_W-1:0]};
    else
      return {1'b0, x[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] res;

  always_comb begin
    res  = clamp(shift_floor(acc));
    dout = res[OUT_W-1:0];
    clip = res[OUT_W];
  end

endmodule

// File: rtl/sound_mixer_gain.sv
// N-channel mixer: per-channel gain and mute, one-channel-per-clock MAC, saturated output.
// Define SOUND_MIXER_PEAK_EN to add the peak-hold register at address 10.
module sound_mixer_gain
  import sound_mixer_pkg::*;
#(
  parameter int                COUNT        = 3,
  parameter int                WIDTH        = 16,
  parameter int                GAIN_W       = 8,
  parameter logic [GAIN_W-1:0] GAIN_DEFAULT = 8'h40,
  parameter int                REG_AW       = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SAMPLE_STB,
  input  logic [COUNT*WIDTH-1:0]   IN_SIGNAL,
  input  logic                     REG_WE,
  input  logic [REG_AW-1:0]        REG_ADDR,
  input  logic [7:0]               REG_WDATA,
  output logic [7:0]               REG_RDATA,
  output logic signed [WIDTH-1:0]  OUT_SIGNAL,
  output logic                     OUT_VALID,
  output logic                     BUSY
);

  localparam int PROD_W = WIDTH + GAIN_W + 1;
  localparam int ACC_W  = WIDTH + GAIN_W + $clog2(COUNT) + 1;
  localparam int CH_W   = (COUNT > 1) ? $clog2(COUNT) : 1;

  state_e                  state;
  logic [CH_W-1:0]         ch;
  logic [GAIN_W-1:0]       gain [COUNT];
  logic [COUNT-1:0]        mute;
  logic                    overrun;
  logic                    clip;

  logic signed [WIDTH-1:0] smp_p0 [COUNT];
  logic [GAIN_W-1:0]       gain_p0 [COUNT];
  logic [COUNT-1:0]        mute_p0;
  logic signed [ACC_W-1:0] acc_p1;

  logic signed [PROD_W-1:0] smp_x, gain_x, prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [WIDTH-1:0]  sat_out;
  logic                     sat_clip;

  logic                     start;
  logic                     last_ch;
  logic [COUNT-1:0]         wr_gain;
  logic                     wr_mute;
  logic                     wr_status;

  assign BUSY    = (state != ST_IDLE);
  assign start   = (state == ST_IDLE) && SAMPLE_STB;
  assign last_ch = (state == ST_ACC) && (ch == CH_W'(COUNT - 1));

  always_comb begin
    wr_gain = '0;
    for (int i = 0; i < COUNT; i++)
      wr_gain[i] = REG_WE && (REG_ADDR == REG_AW'(REG_GAIN_BASE + i));
    wr_mute   = REG_WE && (REG_ADDR == REG_AW'(REG_MUTE));
    wr_status = REG_WE && (REG_ADDR == REG_AW'(REG_STATUS));
  end

  // Stage p0 -> p1: the head of the snapshot shift register feeds the multiplier.
  always_comb begin
    smp_x    = PROD_W'(smp_p0[0]);
    gain_x   = PROD_W'({1'b0, gain_p0[0]});
    prod     = mute_p0[0] ? '0 : smp_x * gain_x;
    acc_next = acc_p1 + ACC_W'(prod);
  end

  // The final channel's sum is saturated directly so the result lands on the SAT cycle.
  sound_mixer_sat #(
    .IN_W  (ACC_W),
    .OUT_W (WIDTH),
    .SHIFT (GAIN_W - 1)
  ) u_sat (
    .acc  (acc_next),
    .dout (sat_out),
    .clip (sat_clip)
  );

  always_ff @(posedge CLK) begin
    if (start) begin
      for (int i = 0; i < COUNT; i++) begin
        smp_p0[i]  <= IN_SIGNAL[i*WIDTH +: WIDTH];
        gain_p0[i] <= gain[i];
      end
      mute_p0 <= mute;
      acc_p1  <= '0;
    end else if (state == ST_ACC) begin
      for (int i = 0; i < COUNT - 1; i++) begin
        smp_p0[i]  <= smp_p0[i+1];
        gain_p0[i] <= gain_p0[i+1];
      end
      mute_p0 <= mute_p0 >> 1;
      acc_p1  <= acc_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      ch         <= '0;
      OUT_SIGNAL <= '0;
      OUT_VALID  <= 1'b0;
      overrun    <= 1'b0;
      clip       <= 1'b0;
      mute       <= '0;
      for (int i = 0; i < COUNT; i++)
        gain[i] <= GAIN_DEFAULT;
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (SAMPLE_STB) begin
            state <= ST_ACC;
            ch    <= '0;
          end
        end
        ST_ACC: begin
          ch <= ch + 1'b1;
          if (last_ch) begin
            state      <= ST_SAT;
            OUT_SIGNAL <= sat_out;
            OUT_VALID  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      for (int i = 0; i < COUNT; i++)
        if (wr_gain[i])
          gain[i] <= GAIN_W'(REG_WDATA);
      if (wr_mute)
        mute <= COUNT'(REG_WDATA);

      // A flag being set wins over a coincident write-1-to-clear.
      if (SAMPLE_STB && state != ST_IDLE)
        overrun <= 1'b1;
      else if (wr_status && REG_WDATA[STAT_OVERRUN])
        overrun <= 1'b0;

      if (last_ch && sat_clip)
        clip <= 1'b1;
      else if (wr_status && REG_WDATA[STAT_CLIP])
        clip <= 1'b0;
    end
  end

`ifdef SOUND_MIXER_PEAK_EN
  logic [7:0]       peak;
  logic [WIDTH-1:0] mag;
  logic [7:0]       mag_hi;
  logic             wr_peak;

  assign wr_peak = REG_WE && (REG_ADDR == REG_AW'(REG_PEAK));

  // The most negative sample has no positive twin; fold it onto the positive limit.
  always_comb begin
    mag = sat_out[WIDTH-1] ? WIDTH'(-sat_out) : WIDTH'(sat_out);
    if (sat_out == {1'b1, {(WIDTH-1){1'b0}}})
      mag = {1'b0, {(WIDTH-1){1'b1}}};
    mag_hi = mag[WIDTH-1 -: 8];
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      peak <= '0;
    else if (last_ch && (wr_peak || mag_hi > peak))
      peak <= mag_hi;
    else if (wr_peak)
      peak <= '0;
  end
`endif

  always_comb begin
    REG_RDATA = '0;
    for (int i = 0; i < COUNT; i++)
      if (REG_ADDR == REG_AW'(REG_GAIN_BASE + i))
        REG_RDATA = 8'(gain[i]);
    if (REG_ADDR == REG_AW'(REG_MUTE))
      REG_RDATA = 8'(mute);
    if (REG_ADDR == REG_AW'(REG_STATUS)) begin
      REG_RDATA[STAT_OVERRUN] = overrun;
      REG_RDATA[STAT_BUSY]    = BUSY;
      REG_RDATA[STAT_CLIP]    = clip;
    end
`ifdef SOUND_MIXER_PEAK_EN
    if (REG_ADDR == REG_AW'(REG_PEAK))
      REG_RDATA = peak;
`endif
  end

endmodule

// File: tb/tb_sound_mixer_gain.sv
// Scoreboard bench for sound_mixer_gain: a plain-arithmetic mix model predicts each
// output sample and its arrival cycle; a negedge monitor pops and compares.
module tb_sound_mixer_gain;

  localparam int COUNT  = 3;
  localparam int WIDTH  = 16;
  localparam int GAIN_W = 8;
  localparam int REG_AW = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    stb;
  logic [COUNT*WIDTH-1:0]  in_sig;
  logic                    we;
  logic [REG_AW-1:0]       addr;
  logic [7:0]              wdata;
  logic [7:0]              rdata;
  logic signed [WIDTH-1:0] out_sig;
  logic                    out_vld;
  logic                    busy;

  always #5 clk = ~clk;

  sound_mixer_gain #(
    .COUNT(COUNT), .WIDTH(WIDTH), .GAIN_W(GAIN_W), .GAIN_DEFAULT(8'h40), .REG_AW(REG_AW)
  ) dut (
    .CLK(clk), .RESET(rst), .SAMPLE_STB(stb), .IN_SIGNAL(in_sig),
    .REG_WE(we), .REG_ADDR(addr), .REG_WDATA(wdata), .REG_RDATA(rdata),
    .OUT_SIGNAL(out_sig), .OUT_VALID(out_vld), .BUSY(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int val; } exp_t;
  exp_t q[$];

  // Reference state, updated when a stimulus is issued.
  int m_gain [COUNT];
  int m_mute;
  bit m_ovr, m_clip;
  bit frame_on;
  int frame_t;
  int cur_s [COUNT];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Gain is a fraction of 2^(GAIN_W-1); the sum is floored then clamped to WIDTH.
  function automatic int model_mix(output bit clipped);
    longint sum = 0;
    longint unity = longint'(1) << (GAIN_W - 1);
    longint hi = (longint'(1) << (WIDTH - 1)) - 1;
    longint lo = -(longint'(1) << (WIDTH - 1));
    longint v;
    for (int i = 0; i < COUNT; i++)
      if (!m_mute[i]) sum += longint'(cur_s[i]) * longint'(m_gain[i]);
    v = sum / unity;
    if (sum < 0 && (sum % unity) != 0) v = v - 1;
    clipped = 1'b0;
    if (v > hi) begin v = hi; clipped = 1'b1; end
    if (v < lo) begin v = lo; clipped = 1'b1; end
    return int'(v);
  endfunction

  function automatic bit model_busy();
    return frame_on && cyc >= frame_t + 1 && cyc <= frame_t + COUNT + 1;
  endfunction

  function automatic int exp_reg(input int a);
    if (a < COUNT) return m_gain[a];
    if (a == 8) return m_mute;
    if (a == 9) return (int'(m_clip) << 2) | (int'(model_busy()) << 1) | int'(m_ovr);
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < COUNT; i++) m_gain[i] = 'h40;
    m_mute = 0; m_ovr = 0; m_clip = 0; frame_on = 0;
  endfunction

  // One clock of stimulus, launched 1 time unit after a rising edge.
  task automatic drive(input bit s, input bit w, input int a, input int d);
    int t = cyc;
    bit ovr_set = 1'b0;
    bit clipped;
    exp_t e;
    if (s) begin
      if (!frame_on || t >= frame_t + COUNT + 2) begin
        e.due = t + COUNT + 1;
        e.val = model_mix(clipped);
        q.push_back(e);
        if (clipped) m_clip = 1'b1;
        frame_on = 1'b1;
        frame_t = t;
      end else begin
        m_ovr = 1'b1;
        ovr_set = 1'b1;
      end
    end
    if (w) begin
      if (a < COUNT) m_gain[a] = d & 'hFF;
      else if (a == 8) m_mute = d & ((1 << COUNT) - 1);
      else if (a == 9) begin
        if (d[0] && !ovr_set) m_ovr = 1'b0;
        if (d[2]) m_clip = 1'b0;
      end
    end
    stb = s; we = w; addr = REG_AW'(a); wdata = 8'(d);
    for (int i = 0; i < COUNT; i++) in_sig[i*WIDTH +: WIDTH] = cur_s[i][WIDTH-1:0];
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    drive(1'b0, 1'b1, a, d);
  endtask

  task automatic strobe(input int s0, input int s1, input int s2);
    cur_s[0] = s0; cur_s[1] = s1; cur_s[2] = s2;
    drive(1'b1, 1'b0, 0, 0);
  endtask

  task automatic rd(input string name, input int a);
    addr = REG_AW'(a);
    #1;
    chk(name, rdata, exp_reg(a));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin idle(1); n++; end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    idle(2);
  endtask

  task automatic do_reset();
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every OUT_VALID must match the oldest expectation, on its predicted cycle.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_vld === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_cycle", cyc, e.due);
          chk("out_signal", out_sig, e.val);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_out_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    stb = 0; we = 0; addr = '0; wdata = '0; in_sig = '0; rst = 1'b1;
    for (int i = 0; i < COUNT; i++) cur_s[i] = 0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    chk("reset_out_signal", out_sig, 0);
    chk("reset_out_valid", out_vld, 0);
    chk("reset_busy", busy, 0);
    for (int a = 0; a < 16; a++) rd("reset_reg", a);

    // Defaults and latency.
    strobe(1000, 2000, -500);
    chk("busy_after_strobe", busy, 1);
    drain();
    rd("status_after_default", 9);

    // Saturation high and low, then clear CLIP.
    for (int i = 0; i < COUNT; i++) wr(i, 'hFF);
    strobe(32767, 32767, 32767);
    drain();
    rd("status_clip_set", 9);
    strobe(-32768, -32768, -32768);
    drain();
    wr(9, 'h04);
    rd("status_clip_cleared", 9);

    // Unity gain with a muted channel.
    wr(0, 'h80); wr(2, 'h40); wr(8, 'h02);
    rd("mute_readback", 8);
    rd("gain0_readback", 0);
    strobe(1000, 2000, -500);
    drain();
    wr(8, 0);

    // Overrun from a strobe two cycles into a frame, then clear.
    strobe(300, -700, 1200);
    idle(1);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    rd("status_overrun", 9);
    wr(9, 'h01);
    rd("status_overrun_clr", 9);

    // Clear coincident with a fresh overrun: set wins.
    strobe(10, 20, 30);
    idle(1);
    drive(1'b1, 1'b1, 9, 'h01);
    drain();
    rd("status_set_wins", 9);
    wr(9, 'h01);

    // Strobe on the SAT cycle is also an overrun.
    strobe(5, 6, 7);
    idle(COUNT);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    rd("status_sat_overrun", 9);
    wr(9, 'h01);

    // Gain change mid-frame applies to the next frame only.
    strobe(4000, -3000, 2500);
    wr(0, 0);
    drain();
    strobe(4000, -3000, 2500);
    drain();

    // Reset mid-frame.
    wr(1, 'h11);
    strobe(1000, 2000, -500);
    idle(1);
    do_reset();
    chk("midreset_busy", busy, 0);
    chk("midreset_out_signal", out_sig, 0);
    idle(COUNT + 3);
    rd("midreset_gain1", 1);
    rd("midreset_status", 9);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 3) begin
        wr(int'($urandom_range(0, 8)), int'($urandom_range(0, 255)));
      end else if (r < 7) begin
        for (int i = 0; i < COUNT; i++)
          cur_s[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                                 : int'($signed(16'($urandom)));
        drive(1'b1, 1'b0, 0, 0);
      end else begin
        idle(int'($urandom_range(1, 3)));
      end
    end
    drain();
    rd("random_status", 9);
    for (int a = 0; a < 9; a++) rd("random_reg", a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_mixer_gain.md
Name: sound_mixer_gain

Overview:
- Parametrised N-channel sound mixer with per-channel programmable gain and per-channel mute.
- Replaces the fixed attenuator-plus-mixer chains that sit between the cartridge sound sources (MEGAROM SCC, FM, PSG) and the external/internal sound outputs.
- Gains are host-programmable through a small register port driven by the MSX bus decoder.
- A time-multiplexed multiply-accumulate engine processes one channel per clock, then saturates the sum to the output width.

Parameters:
- COUNT, 3, number of input channels (1..8).
- WIDTH, 16, signed sample width of inputs and output.
- GAIN_W, 8, unsigned gain width; unity gain = 1 << (GAIN_W-1).
- GAIN_DEFAULT, 8'h40, reset gain of every channel (0.5).
- REG_AW, 4, register address width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- SAMPLE_STB  in  1  one-cycle pulse that starts one mix frame.
- IN_SIGNAL  in  COUNT*WIDTH  signed samples; channel i occupies [i*WIDTH +: WIDTH].
- REG_WE  in  1  register write strobe.
- REG_ADDR  in  REG_AW  register address.
- REG_WDATA  in  8  write data.
- REG_RDATA  out  8  combinational read data for REG_ADDR.
- OUT_SIGNAL  out  WIDTH  signed mixed sample; held between frames.
- OUT_VALID  out  1  one-cycle pulse when OUT_SIGNAL updates.
- BUSY  out  1  high while a frame is in progress.

Behaviour:
- Reset values: OUT_SIGNAL=0, OUT_VALID=0, BUSY=0; all gains = GAIN_DEFAULT; mute=0; status flags=0; state=IDLE.
- Register map:
  - 0..7: gain of channel n; addresses >= COUNT read 0 and ignore writes.
  - 8: mute mask, bit i mutes channel i; bits >= COUNT read 0.
  - 9: status. bit0 OVERRUN (sticky, write 1 to clear), bit1 BUSY (read-only), bit2 CLIP (sticky, write 1 to clear).
  - Unmapped addresses read 0; writes to them are ignored.
- Register writes take effect the next cycle.
- States: IDLE -> ACC -> SAT -> IDLE.
- IDLE:
  - On SAMPLE_STB, snapshot all IN_SIGNAL channels, gains and the mute mask.
  - Clear the accumulator, set ch=0, enter ACC. BUSY rises the following cycle.
- ACC:
  - Each cycle: acc += muted ? 0 : sample[ch]*gain[ch].
  - Product is signed WIDTH+GAIN_W+1 bits (gain zero-extended).
  - Accumulator is WIDTH+GAIN_W+$clog2(COUNT)+1 bits and never overflows.
  - ch increments; after ch==COUNT-1, enter SAT.
- SAT:
  - Arithmetic right shift of acc by GAIN_W-1 (floor rounding).
  - Clamp to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1]; set CLIP if clamped.
  - Register OUT_SIGNAL, pulse OUT_VALID, return to IDLE.
- Latency: with SAMPLE_STB at cycle t, OUT_VALID is high at cycle t+COUNT+1. Minimum strobe spacing is COUNT+2 cycles.
- SAMPLE_STB when not IDLE (including the SAT cycle): the strobe is ignored, OVERRUN is set, and the current frame completes unchanged.
- Gain or mute writes during a frame affect the next frame only, because the engine uses the snapshot.
- Simultaneous flag set and write-1-clear in the same cycle: set wins.
- RESET mid-frame: return to IDLE immediately; no OUT_VALID for the aborted frame; OUT_SIGNAL=0.

Optional Feature:
- Macro SOUND_MIXER_PEAK_EN.
- Defined:
  - Adds a peak-hold register at address 10 holding the upper 8 bits of max |OUT_SIGNAL| seen since the last clear.
  - |-2^(WIDTH-1)| saturates to 2^(WIDTH-1)-1.
  - Updated on OUT_VALID; any write to address 10 clears it (update wins on the same cycle); reset value 0.
- Undefined: address 10 reads 0; no peak logic is present.

Decomposition:
- Package sound_mixer_pkg holds:
  - the state enum (IDLE/ACC/SAT);
  - register address constants (REG_GAIN_BASE=0, REG_MUTE=8, REG_STATUS=9, REG_PEAK=10);
  - status bit indices;
  - the GAIN_UNITY helper function.
- One sub-module, sound_mixer_sat: a combinational shift-and-clamp from accumulator width to WIDTH, emitting a clip flag. Also reused by future mixers.

Test Plan:
- Defaults and latency: COUNT=3, gains 0x40, inputs 1000/2000/-500, strobe at t -> OUT_VALID only at t+4; OUT_SIGNAL=1250; CLIP=0.
- Saturation: gains 0xFF, inputs all 32767 -> OUT_SIGNAL=32767, CLIP=1. Inputs all -32768 -> OUT_SIGNAL=-32768. Write 0x04 to address 9 -> CLIP=0.
- Mute and unity: gain0=0x80, mute=0x02, inputs 1000/2000/-500 with gain2=0x40 -> OUT_SIGNAL=1000-250=750.
- Overrun: second strobe at t+2 -> only one OUT_VALID (t+4); status bit0=1; write 0x01 to address 9 -> bit0=0. A clear coincident with a new overrun leaves bit0=1.
- Gain write mid-frame: write gain0=0 at t+1 -> frame result uses the old gain; the next frame excludes channel 0.
- Reset mid-frame: RESET at t+2 -> BUSY=0 and OUT_SIGNAL=0 next cycle; no OUT_VALID at t+4; gains back to 0x40.
